// File: rtl/pfa_pkg.sv
// Shared types for the pipelined-full-adder nibble packer.
// Contents: nibble width constant, nibble type, collect-FSM state enum.
package pfa_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collect_state_e;

endpackage : pfa_pkg

// File: rtl/pfa_out_slot.sv
// Single-entry valid/ready output register for packed words.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load_i          a completed word is written this cycle
//   word_i/cout_i/nibs_i  payload of the completed word
//   out_ready       consumer takes the held word this cycle
//   out_valid/out_word/out_cout/out_nibs  registered slot contents
//   free_c          slot can take a new word this cycle (combinational)
module pfa_out_slot #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned NIBS_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              cout_i,
    input  logic [NIBS_W-1:0] nibs_i,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              out_cout,
    output logic [NIBS_W-1:0] out_nibs,
    output logic              free_c
);

    logic              valid_q;
    logic [WORD_W-1:0] word_q;
    logic              cout_q;
    logic [NIBS_W-1:0] nibs_q;

    // A load always wins: it is only issued when the slot is free, which
    // covers reloading in the same cycle as a handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            cout_q  <= 1'b0;
            nibs_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= word_i;
            cout_q  <= cout_i;
            nibs_q  <= nibs_i;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign free_c    = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_cout  = cout_q;
    assign out_nibs  = nibs_q;

endmodule : pfa_out_slot

// File: rtl/pfa_nibble_packer.sv
// Packs NIBBLES adder sum nibbles (LSB first) into one word, feeds the
// running carry back to the adder cin, and offers words on a valid/ready slot.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        input nibble handshake
//   in_sum, in_carry, in_last  nibble, carry vector (bit 3 used), early end
//   carry_fb                 registered carry for the adder's next cin
//   out_valid/out_ready      output word handshake
//   out_word, out_cout, out_nibs  packed word, final carry, nibble count
//   ovf_cnt                  words delivered with out_cout=1 (PACKER_OVF_CNT_EN)
// Build option: define PACKER_OVF_CNT_EN to add the saturating ovf_cnt port.
module pfa_nibble_packer
    import pfa_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  nibble_t                       in_sum,
    input  logic [NIBBLE_W-1:0]           in_carry,
    input  logic                          in_last,
    output logic                          carry_fb,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_word,
    output logic                          out_cout,
    output logic [$clog2(NIBBLES+1)-1:0]  out_nibs
`ifdef PACKER_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0]              ovf_cnt
`endif
);

    localparam int unsigned WORD_W = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W  = $clog2(NIBBLES);
    localparam int unsigned NIBS_W = $clog2(NIBBLES + 1);

    collect_state_e    state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              carry_q, carry_d;

    logic              accept_c;
    logic              done_c;
    logic              load_c;
    logic              free_c;
    logic [WORD_W-1:0] word_c;
    logic [NIBS_W-1:0] nibs_c;

    // Only carry bit 3 matters downstream.
    logic unused_c;
    assign unused_c = ^in_carry[2:0];

    assign in_ready = rst && free_c;
    assign accept_c = in_valid && in_ready;
    assign done_c   = in_last || (idx_q == IDX_W'(NIBBLES - 1));
    assign nibs_c   = NIBS_W'(idx_q) + NIBS_W'(1);

    // Collect state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            carry_q <= carry_d;
        end
    end

    // Next-state: insert nibble, then either finish the word or advance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        carry_d = carry_q;
        load_c  = 1'b0;
        // Upper nibbles of buf are still zero, so the word is zero-filled.
        word_c  = buf_q;
        word_c[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = in_sum;

        if (accept_c) begin
            if (done_c) begin
                load_c  = 1'b1;
                idx_d   = '0;
                buf_d   = '0;
                carry_d = 1'b0;
                state_d = IDLE;
            end else begin
                buf_d   = word_c;
                idx_d   = idx_q + IDX_W'(1);
                carry_d = in_carry[NIBBLE_W-1];
                state_d = COLLECT;
            end
        end
    end

    assign carry_fb = carry_q;

    pfa_out_slot #(
        .WORD_W (WORD_W),
        .NIBS_W (NIBS_W)
    ) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_c),
        .word_i    (word_c),
        .cout_i    (in_carry[NIBBLE_W-1]),
        .nibs_i    (nibs_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_cout  (out_cout),
        .out_nibs  (out_nibs),
        .free_c    (free_c)
    );

`ifdef PACKER_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_q;

    // Saturating count of delivered words that carried out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= '0;
        end else if (out_valid && out_ready && out_cout && (ovf_q != '1)) begin
            ovf_q <= ovf_q + CNT_W'(1);
        end
    end

    assign ovf_cnt = ovf_q;
`else
    logic [CNT_W-1:0] unused_cnt_c;
    assign unused_cnt_c = '0;
`endif

endmodule : pfa_nibble_packer

// File: tb/tb_pfa_nibble_packer.sv
// Directed bench for pfa_nibble_packer (NIBBLES=4).
module tb_pfa_nibble_packer;

`ifdef PACKER_OVF_CNT_EN
    localparam int unsigned TB_CNT_W = 2;
`else
    localparam int unsigned TB_CNT_W = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sum;
    logic [3:0]  in_carry;
    logic        in_last;
    logic        carry_fb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_cout;
    logic [2:0]  out_nibs;
`ifdef PACKER_OVF_CNT_EN
    logic [TB_CNT_W-1:0] ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pfa_nibble_packer #(
        .NIBBLES (4),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .carry_fb  (carry_fb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_cout  (out_cout),
        .out_nibs  (out_nibs)
`ifdef PACKER_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  sum;
        logic [3:0]  car;
        logic        last;
        logic        ordy;
        logic        e_rdy;   // in_ready before the edge
        logic        e_cfb;   // after the edge
        logic        e_ov;
        logic        chk_dat; // compare word/cout/nibs after the edge
        logic [15:0] e_word;
        logic        e_cout;
        logic [2:0]  e_nibs;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic iv, logic [3:0] s, logic [3:0] c,
                                logic l, logic ordy, logic e_rdy, logic e_cfb,
                                logic e_ov, logic chk, logic [15:0] w,
                                logic co, logic [2:0] n);
        vec_t v;
        v.rst = r; v.iv = iv; v.sum = s; v.car = c; v.last = l; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_cfb = e_cfb; v.e_ov = e_ov; v.chk_dat = chk;
        v.e_word = w; v.e_cout = co; v.e_nibs = n;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [3:0] s,
                         input logic [3:0] c, input logic l, input logic ordy);
        rst = r; in_valid = iv; in_sum = s; in_carry = c; in_last = l; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

        //   rst iv sum   car   lst ordy | rdy cfb ov chk word     cout nibs
        // reset held with in_valid=1
        add(0, 1, 4'h5, 4'h0, 0, 1,  0, 0, 0, 1, 16'h0000, 0, 3'd0);
        add(0, 1, 4'h5, 4'h0, 0, 1,  0, 0, 0, 1, 16'h0000, 0, 3'd0);
        // full word 0x4321, then out_valid drops after one cycle
        add(1, 1, 4'h1, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h2, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h3, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h4, 4'h0, 0, 1,  1, 0, 1, 1, 16'h4321, 0, 3'd4);
        add(1, 0, 4'h0, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        // early end with carry chain
        add(1, 1, 4'hF, 4'h8, 0, 1,  1, 1, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h0, 4'h8, 1, 1,  1, 0, 1, 1, 16'h000F, 1, 3'd2);
        add(1, 0, 4'h0, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        // backpressure on word 0x8765; nibble 0x9 offered but held off
        add(1, 1, 4'h5, 4'h0, 0, 0,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h6, 4'h0, 0, 0,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h7, 4'h0, 0, 0,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h8, 4'h0, 0, 0,  1, 0, 1, 1, 16'h8765, 0, 3'd4);
        add(1, 1, 4'h9, 4'h0, 0, 0,  0, 0, 1, 1, 16'h8765, 0, 3'd4);
        add(1, 1, 4'h9, 4'h0, 0, 0,  0, 0, 1, 1, 16'h8765, 0, 3'd4);
        add(1, 1, 4'h9, 4'h0, 0, 0,  0, 0, 1, 1, 16'h8765, 0, 3'd4);
        add(1, 1, 4'h9, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hA, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hB, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hC, 4'h0, 0, 1,  1, 0, 1, 1, 16'hCBA9, 0, 3'd4);
        add(1, 0, 4'h0, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        // single-nibble words back to back: handshake and reload together
        add(1, 1, 4'h3, 4'h8, 1, 1,  1, 0, 1, 1, 16'h0003, 1, 3'd1);
        add(1, 1, 4'h7, 4'h0, 1, 1,  1, 0, 1, 1, 16'h0007, 0, 3'd1);
        add(1, 0, 4'h0, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        // reset mid-word discards 0x5,0x6; gap mid-word; in_last on nibble 3
        add(1, 1, 4'h5, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'h6, 4'h8, 0, 1,  1, 1, 0, 0, 16'h0000, 0, 3'd0);
        add(0, 0, 4'h0, 4'h0, 0, 1,  0, 0, 0, 1, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hA, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hB, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 0, 4'hF, 4'h8, 1, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hC, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);
        add(1, 1, 4'hD, 4'h0, 1, 1,  1, 0, 1, 1, 16'hDCBA, 0, 3'd4);
        add(1, 0, 4'h0, 4'h0, 0, 1,  1, 0, 0, 0, 16'h0000, 0, 3'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sum, vecs[i].car,
                  vecs[i].last, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d carry_fb", i), 32'(carry_fb), 32'(vecs[i].e_cfb));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].chk_dat) begin
                chk($sformatf("v%0d out_word", i), 32'(out_word), 32'(vecs[i].e_word));
                chk($sformatf("v%0d out_cout", i), 32'(out_cout), 32'(vecs[i].e_cout));
                chk($sformatf("v%0d out_nibs", i), 32'(out_nibs), 32'(vecs[i].e_nibs));
            end
        end

        // Long idle mid-word: carry and partial word must hold.
        begin
            bit seen;
            drive(1'b1, 1'b1, 4'h1, 4'h8, 1'b0, 1'b1);
            tick();
            drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
            for (int k = 0; k < 20; k++) begin
                tick();
                chk("idle carry_fb", 32'(carry_fb), 32'd1);
                chk("idle out_valid", 32'(out_valid), 32'd0);
            end
            drive(1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0);
            tick();
            drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                if (out_valid) seen = 1'b1;
                else tick();
            end
            chk("idle word arrives", 32'(seen), 32'd1);
            chk("idle out_word", 32'(out_word), 32'h0021);
            chk("idle out_nibs", 32'(out_nibs), 32'd2);
            chk("idle out_cout", 32'(out_cout), 32'd0);
            chk("idle carry_fb cleared", 32'(carry_fb), 32'd0);
            out_ready = 1'b1;
            tick();
            chk("idle drained", 32'(out_valid), 32'd0);
        end

`ifdef PACKER_OVF_CNT_EN
        // Saturating overflow counter with a 2-bit width.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 4'(k), 4'h8, 1'b1, 1'b1);
            tick();
            drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
            tick();
            chk($sformatf("ovf_cnt word %0d", k), 32'(ovf_cnt),
                (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pfa_nibble_packer
